// File: rtl/serial_tx_shift_if.sv
// Producer-side handshake and serial line bundle for serial_tx_shift.
// The producer holds the master modport and the transmitter holds the slave modport.
interface serial_tx_shift_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             ready;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output data_in, data_valid,
    input  ready, serial_out, busy, done
  );

  modport slave (
    input  data_in, data_valid,
    output ready, serial_out, busy, done
  );
endinterface

// File: rtl/serial_tx_shift.sv
// Parallel-in, serial-out frame transmitter: start bit (0), WIDTH data bits LSB-first, stop bit (1).
// Each bit is held for CLKS_PER_BIT clocks, and every output is registered.
module serial_tx_shift #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic            clock,
  input  logic            clear,
  serial_tx_shift_if.slave bus
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CW-1:0]    cyc;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             cyc_wrap;

  assign cyc_wrap = (cyc == CYC_LAST);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state          <= IDLE;
      cyc            <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      bus.ready      <= 1'b1;
      bus.serial_out <= 1'b1;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      // The cycle counter free-runs inside a frame; each wrap closes the current bit.
      if (state == IDLE) cyc <= '0;
      else               cyc <= cyc_wrap ? '0 : cyc + 1'b1;

      case (state)
        IDLE: begin
          if (bus.data_valid && bus.ready) begin
            shreg          <= bus.data_in;
            bit_cnt        <= '0;
            state          <= START;
            bus.serial_out <= 1'b0;
            bus.ready      <= 1'b0;
            bus.busy       <= 1'b1;
          end
        end
        START: begin
          if (cyc_wrap) begin
            state          <= DATA;
            bus.serial_out <= shreg[0];
            shreg          <= shreg >> 1;
          end
        end
        DATA: begin
          if (cyc_wrap) begin
            if (bit_cnt == BIT_LAST) begin
              state          <= STOP;
              bus.serial_out <= 1'b1;
            end else begin
              bit_cnt        <= bit_cnt + 1'b1;
              bus.serial_out <= shreg[0];
              shreg          <= shreg >> 1;
            end
          end
        end
        STOP: begin
          if (cyc_wrap) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_tx_shift.sv
// Directed bench for serial_tx_shift: a default-size instance (8 bits, 4 clocks per bit)
// plus a fast instance (4 bits, 1 clock per bit).
module tb_serial_tx_shift;
  logic clock = 1'b0;
  logic clear = 1'b0;
  logic clear_f = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [5:0] fexp;

  serial_tx_shift_if #(.WIDTH(8)) b ();
  serial_tx_shift_if #(.WIDTH(4)) f ();

  serial_tx_shift #(.WIDTH(8), .CLKS_PER_BIT(4)) dut (
    .clock(clock), .clear(clear), .bus(b)
  );
  serial_tx_shift #(.WIDTH(4), .CLKS_PER_BIT(1)) dut_f (
    .clock(clock), .clear(clear_f), .bus(f)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s k=%0d: observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  // Checks one default frame; the first check is the cycle after accept edge T0.
  task automatic watch(input logic [7:0] d, input int drop_k, input int ign_k);
    logic exp_so;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clock);
      exp_so = (k < 4) ? 1'b0 : (k < 36) ? d[(k-4)/4] : 1'b1;
      chk("serial_out", k, b.serial_out, exp_so);
      chk("done", k, b.done, k == 40);
      chk("busy", k, b.busy, k < 40);
      chk("ready", k, b.ready, k >= 40);
      if (k == drop_k) b.data_valid = 1'b0;
      if (k == ign_k) begin
        b.data_valid = 1'b1;
        b.data_in    = 8'hFF;
      end
    end
  endtask

  initial begin
    b.data_in = '0; b.data_valid = 1'b0;
    f.data_in = '0; f.data_valid = 1'b0;

    // Asynchronous clear before any clock edge.
    #2 clear = 1'b1; clear_f = 1'b1;
    #1;
    chk("rst_ready", 0, b.ready, 1'b1);
    chk("rst_serial", 0, b.serial_out, 1'b1);
    chk("rst_busy", 0, b.busy, 1'b0);
    chk("rst_done", 0, b.done, 1'b0);
    chk("rst_f_serial", 0, f.serial_out, 1'b1);
    chk("rst_f_ready", 0, f.ready, 1'b1);
    repeat (2) @(negedge clock);
    clear = 1'b0; clear_f = 1'b0;
    @(negedge clock);
    chk("idle_serial", 0, b.serial_out, 1'b1);
    chk("idle_ready", 0, b.ready, 1'b1);

    // Single frame 8'hA5; data_in changes after T0 must not matter.
    b.data_valid = 1'b1; b.data_in = 8'hA5;
    @(posedge clock); #1 b.data_in = 8'h00;
    watch(8'hA5, 0, -1);
    @(negedge clock);
    chk("a5_done_drop", 41, b.done, 1'b0);
    chk("a5_idle_busy", 41, b.busy, 1'b0);

    // Request of 8'hFF during a frame is ignored and not queued.
    b.data_valid = 1'b1; b.data_in = 8'h5A;
    @(posedge clock); #1 b.data_valid = 1'b0;
    watch(8'h5A, 38, 10);
    for (int k = 41; k < 44; k++) begin
      @(negedge clock);
      chk("ign_serial", k, b.serial_out, 1'b1);
      chk("ign_busy", k, b.busy, 1'b0);
      chk("ign_done", k, b.done, 1'b0);
    end

    // Back-to-back frames with data_valid held high; second accept at T0+41.
    b.data_valid = 1'b1; b.data_in = 8'h01;
    @(posedge clock); #1 b.data_in = 8'h80;
    watch(8'h01, -1, -1);
    watch(8'h80, 0, -1);
    @(negedge clock);
    chk("b2b_done_drop", 41, b.done, 1'b0);

    // Clear during data bit 3 abandons the frame without a done pulse.
    b.data_valid = 1'b1; b.data_in = 8'hF7;
    @(posedge clock); #1 b.data_valid = 1'b0;
    repeat (17) @(negedge clock);
    chk("clr_bit3", 16, b.serial_out, 1'b0);
    chk("clr_busy_pre", 16, b.busy, 1'b1);
    @(posedge clock); #2 clear = 1'b1;
    #1;
    chk("clr_serial", 17, b.serial_out, 1'b1);
    chk("clr_ready", 17, b.ready, 1'b1);
    chk("clr_busy", 17, b.busy, 1'b0);
    chk("clr_done", 17, b.done, 1'b0);
    @(negedge clock); clear = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      chk("clr_no_done", k, b.done, 1'b0);
    end
    b.data_valid = 1'b1; b.data_in = 8'h3C;
    @(posedge clock); #1 b.data_valid = 1'b0;
    watch(8'h3C, 0, -1);

    // Fast config: 4'b1100 at one bit per clock -> 0,0,0,1,1,1 then done at T0+6.
    fexp = 6'b111000;
    @(negedge clock);
    f.data_valid = 1'b1; f.data_in = 4'b1100;
    @(posedge clock); #1 f.data_valid = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clock);
      if (k < 6) chk("fast_serial", k, f.serial_out, fexp[k]);
      chk("fast_done", k, f.done, k == 6);
      chk("fast_busy", k, f.busy, k < 6);
    end
    @(negedge clock);
    chk("fast_done_drop", 7, f.done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
